// File: rtl/load_store_unit.sv
// Data-memory access stage: one handshaked access per request,
// with store lane formatting, load extraction and bounded wait.
module load_store_unit #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        ls_op,
   input  logic [63:0]       addr,
   input  logic [63:0]       store_data,
   input  logic [4:0]        dest_reg,
   output logic              resp_valid,
   output logic [63:0]       resp_data,
   output logic [4:0]        resp_reg,
   output logic              resp_err,
   output logic              busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_be,
   output logic [63:0]       mem_wdata,
   input  logic [63:0]       mem_rdata,
   input  logic              mem_ready
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   logic [1:0]  state;
   logic [3:0]  op_q;
   logic [2:0]  lane_q;
   logic [7:0]  cnt;
   logic        misaligned;
   logic [7:0]  be_base;
   logic [63:0] wdata_fmt;
   logic [63:0] shifted;
   logic [63:0] load_fmt;
   logic        timeout_hit;
   logic        unused_addr;

   assign unused_addr = ^addr[63:ADDR_W];

   assign req_ready   = (state == S_IDLE);
   assign busy        = (state != S_IDLE);
   assign resp_valid  = (state == S_RESP);
   assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

   always_comb begin
      misaligned = 1'b0;
      be_base    = 8'h01;
      wdata_fmt  = store_data;
      unique case (ls_op[1:0])
         2'b00: begin
            misaligned = 1'b0;
            be_base    = 8'h01;
            wdata_fmt  = {8{store_data[7:0]}};
         end
         2'b01: begin
            misaligned = addr[0];
            be_base    = 8'h03;
            wdata_fmt  = {4{store_data[15:0]}};
         end
         2'b10: begin
            misaligned = |addr[1:0];
            be_base    = 8'h0F;
            wdata_fmt  = {2{store_data[31:0]}};
         end
         default: begin
            misaligned = |addr[2:0];
            be_base    = 8'hFF;
            wdata_fmt  = store_data;
         end
      endcase
   end

   // Extract the addressed lane, then extend to 64 bits.
   always_comb begin
      shifted  = mem_rdata >> {lane_q, 3'b000};
      load_fmt = shifted;
      unique case (op_q[1:0])
         2'b00:
            load_fmt = op_q[2] ? {{56{shifted[7]}}, shifted[7:0]}
                               : {56'd0, shifted[7:0]};
         2'b01:
            load_fmt = op_q[2] ? {{48{shifted[15]}}, shifted[15:0]}
                               : {48'd0, shifted[15:0]};
         2'b10:
            load_fmt = op_q[2] ? {{32{shifted[31]}}, shifted[31:0]}
                               : {32'd0, shifted[31:0]};
         default:
            load_fmt = shifted;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         op_q      <= 4'd0;
         lane_q    <= 3'd0;
         cnt       <= 8'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= 8'd0;
         mem_wdata <= 64'd0;
         resp_data <= 64'd0;
         resp_reg  <= 5'd0;
         resp_err  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q      <= ls_op;
                  lane_q    <= addr[2:0];
                  resp_reg  <= dest_reg;
                  resp_data <= 64'd0;
                  cnt       <= 8'd0;
                  mem_addr  <= {addr[ADDR_W-1:3], 3'b000};
                  mem_be    <= be_base << addr[2:0];
                  mem_wdata <= wdata_fmt;
                  if (misaligned) begin
                     resp_err <= 1'b1;
                     state    <= S_RESP;
                  end else begin
                     resp_err <= 1'b0;
                     mem_we   <= ls_op[3];
                     mem_req  <= 1'b1;
                     state    <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ready) begin
                  mem_req   <= 1'b0;
                  resp_data <= op_q[3] ? 64'd0 : load_fmt;
                  state     <= S_RESP;
               end else if (timeout_hit) begin
                  mem_req   <= 1'b0;
                  resp_err  <= 1'b1;
                  resp_data <= 64'd0;
                  state     <= S_RESP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle data-memory access stage sitting directly downstream of the uPower core's ALU. It takes the effective address and store data produced by the ALU/register-read stage, performs one handshaked access to the data memory, and formats load data for the register write-back path. It handles lbz/lhz/lha/lwz/lwa/ld and stb/sth/stw/std semantics, with alignment checking and a bounded wait. The core stalls PC update while busy is high.

Parameters:
ADDR_W, 32, data-memory byte-address width; mem_addr carries addr[ADDR_W-1:0] with bits [2:0] forced to 0.
TIMEOUT, 16, maximum ACCESS cycles without mem_ready before the access is aborted with an error; legal range 1..255.

Ports:
clock  input  1  system clock; all state updates on the posedge.
reset_n  input  1  asynchronous, active-low reset.
req_valid  input  1  core presents a memory operation.
req_ready  output  1  unit can accept a request; high only in IDLE.
ls_op  input  4  [1:0] size (00 byte, 01 half, 10 word, 11 dword); [2] sign-extend load; [3] store.
addr  input  64  effective address from the ALU.
store_data  input  64  rt/rs content; the low bytes are significant.
dest_reg  input  5  write-back register index.
resp_valid  output  1  one-cycle pulse when the operation completes.
resp_data  output  64  formatted load result; 0 for stores and errors.
resp_reg  output  5  captured dest_reg.
resp_err  output  1  misalignment or timeout; valid with resp_valid.
busy  output  1  high in ACCESS and RESP.
mem_req  output  1  memory request, held until accepted.
mem_we  output  1  1 = write.
mem_addr  output  ADDR_W  doubleword-aligned address.
mem_be  output  8  byte enables; lane i = bits [8i+7:8i], little-endian.
mem_wdata  output  64  write data, replicated across lanes.
mem_rdata  input  64  read data; sampled when mem_ready is high.
mem_ready  input  1  memory accepts/completes in the same cycle.

Behaviour:
- Reset (asynchronous, immediate): state IDLE. mem_req, mem_we, resp_valid, resp_err and busy all 0. mem_addr, mem_be, mem_wdata, resp_data and resp_reg are 0. Timeout counter is 0. A reset during ACCESS drops mem_req in the same instant; no response is ever produced for the aborted operation.
- State IDLE: req_ready=1. The request is accepted on a posedge when req_valid=1. On acceptance the unit registers ls_op, addr, dest_reg and the formatted write data/byte enables.
- Alignment rule: the access is misaligned when addr mod (1<<size) is nonzero. A misaligned request goes directly to RESP with resp_err=1 and never asserts mem_req.
- Aligned request: go to ACCESS. mem_req=1 from the next cycle. mem_addr, mem_we, mem_be and mem_wdata stay stable until accepted.
- State ACCESS: on a posedge with mem_ready=1, capture the formatted load data (loads only), drop mem_req and go to RESP.
- Timeout: the counter increments on each ACCESS cycle without mem_ready. When the counter reaches TIMEOUT, drop mem_req and go to RESP with resp_err=1 and resp_data=0. mem_ready arriving on that same edge takes priority, so the access completes normally.
- State RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 during RESP, so there are no back-to-back acceptances.
- Latency: with zero-wait memory, the request is accepted at edge 0, mem_req is high in cycle 1, and resp_valid is high in cycle 2. Each memory wait cycle adds one cycle. A misaligned request gives resp_valid in cycle 1.
- Byte enables: lane = addr[2:0]. The enables are 1, 2, 4 or 8 contiguous bits starting at that lane.
- Store write data: the low 8, 16 or 32 bits of store_data are replicated 8, 4 or 2 times respectively; a dword is passed through unchanged.
- Load data: shift mem_rdata right by lane*8, then truncate to the access size. If ls_op[2]=1, sign-extend to 64 bits; otherwise zero-extend. ls_op[2] is ignored for dword accesses and for stores.
- busy = (state != IDLE).
- ls_op, addr and store_data are don't-care outside the acceptance edge.

Test Plan:
- lwz, addr 0x104, mem_rdata 0x8877665544332211, zero-wait memory -> mem_addr 0x100, mem_be 0xF0; resp_valid in cycle 2; resp_data 0x0000000088776655; resp_err 0.
- lha, addr 0x106, same rdata, 3 wait cycles -> resp_data 0xFFFFFFFFFFFF8877 in cycle 5. lhz with the same stimulus -> 0x0000000000008877.
- stb, addr 0x103, store_data 0x...AB -> mem_we 1, mem_be 0x08, mem_wdata 0xABABABABABABABAB; resp_data 0; resp_reg equals dest_reg.
- lwz at addr 0x102 -> mem_req never asserted; resp_valid in cycle 1 with resp_err 1.
- ld with mem_ready held low, TIMEOUT=4 -> mem_req high for 4 cycles then low; resp_err 1; resp_data 0. A second run with mem_ready rising on the 4th edge -> normal completion.
- reset_n pulsed low mid-ACCESS -> mem_req and busy go to 0 immediately, no resp_valid; req_ready is 1 after release.
